// File: rtl/option_packet_buffer.sv
// rtl/option_packet_buffer.sv - assembles WIDTH-bit words into packets and queues them in a DEPTH-entry FIFO
// Optional macro PKTBUF_DROP_CNT_EN adds a saturating drop_count output.
module option_packet_buffer #(
  parameter int WIDTH   = 32,
  parameter int FIELD_W = 32,
  parameter int NFIELDS = 7,
  parameter int DEPTH   = 2,
  localparam int PKT_W  = NFIELDS * FIELD_W,
  localparam int WORDS  = PKT_W / WIDTH,
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] inD,
  output logic             in_ready,
  input  logic             clear,
  input  logic             BS_READY,
  output logic             hasUnusedData,
  output logic [PKT_W-1:0] fields,
`ifdef PKTBUF_DROP_CNT_EN
  output logic [15:0]      drop_count,
`endif
  output logic [LVL_W-1:0] level
);

  logic [PKT_W-1:0] asm_q, asm_d;
  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             last_word, full, accept, push, pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign last_word     = (idx_q == IDX_W'(WORDS - 1));
  assign full          = (level_q == LVL_W'(DEPTH));
  // A completing word needs a free slot; no bypass through a same-cycle pop.
  assign in_ready      = !(full && last_word);
  assign accept        = en && in_ready && !clear;
  assign push          = accept && last_word;
  assign pop           = hasUnusedData && BS_READY && !clear;
  assign hasUnusedData = (level_q != '0);
  assign fields        = mem_q[rd_ptr_q];
  assign level         = level_q;

  always_comb begin
    asm_d    = asm_q;
    idx_d    = idx_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      idx_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (accept) begin
        asm_d[int'(idx_q) * WIDTH +: WIDTH] = inD;
        idx_d = last_word ? '0 : idx_q + 1'b1;
      end
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      asm_q    <= '0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      asm_q    <= asm_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      // asm_d already holds the completing word merged in.
      if (push) mem_q[wr_ptr_q] <= asm_d;
    end
  end

`ifdef PKTBUF_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (clear) begin
      drop_q <= '0;
    end else if (en && !in_ready && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_option_packet_buffer.sv
// tb/tb_option_packet_buffer.sv - directed bench with queue-based packet model and per-cycle output compare
// Honours PKTBUF_DROP_CNT_EN when the design is built with it.
module tb_option_packet_buffer;
  localparam int WIDTH   = 32;
  localparam int FIELD_W = 32;
  localparam int NFIELDS = 7;
  localparam int DEPTH   = 2;
  localparam int PKT_W   = NFIELDS * FIELD_W;
  localparam int WORDS   = PKT_W / WIDTH;
  localparam int LVL_W   = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] inD = '0;
  logic             in_ready;
  logic             clear = 1'b0;
  logic             BS_READY = 1'b0;
  logic             hasUnusedData;
  logic [PKT_W-1:0] fields;
  logic [LVL_W-1:0] level;
`ifdef PKTBUF_DROP_CNT_EN
  logic [15:0]      drop_count;
`endif

  option_packet_buffer #(
    .WIDTH(WIDTH), .FIELD_W(FIELD_W), .NFIELDS(NFIELDS), .DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .en(en),
    .inD(inD),
    .in_ready(in_ready),
    .clear(clear),
    .BS_READY(BS_READY),
    .hasUnusedData(hasUnusedData),
    .fields(fields),
`ifdef PKTBUF_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .level(level)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: complete packets as a queue, the partial packet as a list of words.
  logic [PKT_W-1:0] mq[$];
  logic [WIDTH-1:0] mpart[$];
  int               mdrop = 0;
  bit               m_pop, m_acc;
  logic [PKT_W-1:0] m_pkt;

  function automatic bit m_ready();
    return !(mq.size() == DEPTH && mpart.size() == WORDS - 1);
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset || clear) begin
      mq.delete();
      mpart.delete();
      mdrop = 0;
    end else begin
      m_pop = (mq.size() != 0) && BS_READY;
      m_acc = en && m_ready();
      if (en && !m_ready() && mdrop < 65535) mdrop++;
      if (m_pop) void'(mq.pop_front());
      if (m_acc) begin
        mpart.push_back(inD);
        if (mpart.size() == WORDS) begin
          m_pkt = '0;
          for (int i = 0; i < WORDS; i++) m_pkt[i*WIDTH +: WIDTH] = mpart[i];
          mq.push_back(m_pkt);
          mpart.delete();
        end
      end
    end
  end

  bit          rec_en = 0;
  logic [31:0] popped[$];
  int          max_level = 0;

  always @(negedge clock) begin
    if (reset) begin
      check("in_ready", in_ready, m_ready());
      check("valid", hasUnusedData, mq.size() != 0);
      check("level", level, mq.size());
      if (mq.size() != 0) check("fields", fields, mq[0]);
`ifdef PKTBUF_DROP_CNT_EN
      check("drop_count", drop_count, mdrop);
`endif
      if (rec_en) begin
        if (hasUnusedData && BS_READY) popped.push_back(fields[31:0]);
        if (int'(level) > max_level) max_level = int'(level);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      en  = 1'b1;
      inD = WIDTH'(start + i);
      tick();
    end
    en = 1'b0;
  endtask

  task automatic drain();
    BS_READY = 1'b1;
    while (hasUnusedData) tick();
    BS_READY = 1'b0;
  endtask

  initial begin
    #7;
    check("rst_valid", hasUnusedData, 0);
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_fields", fields, 0);
    #5 reset = 1'b1;
    tick();

    // single packet
    send(1, 7);
    check("t1_valid", hasUnusedData, 1);
    check("t1_level", level, 1);
    for (int k = 0; k < NFIELDS; k++)
      check($sformatf("t1_field%0d", k), fields[k*FIELD_W +: FIELD_W], k + 1);
    drain();

    // back-to-back with consumer always ready
    BS_READY = 1'b1;
    rec_en   = 1;
    send(10, 7);
    send(20, 7);
    send(30, 7);
    tick();
    tick();
    rec_en   = 0;
    BS_READY = 1'b0;
    check("t2_npop", popped.size(), 3);
    if (popped.size() == 3) begin
      check("t2_head0", popped[0], 10);
      check("t2_head1", popped[1], 20);
      check("t2_head2", popped[2], 30);
    end
    check("t2_maxlvl_le1", max_level <= 1, 1);

    // full FIFO backpressure
    send(100, 7);
    send(200, 7);
    send(300, 6);
    check("t3_stall_ready", in_ready, 0);
    check("t3_stall_level", level, 2);
    en  = 1'b1;
    inD = 32'd306;
    tick();
    tick();
    tick();
`ifdef PKTBUF_DROP_CNT_EN
    check("t3_drop3", drop_count, 3);
`endif
    BS_READY = 1'b1;
    tick();
    BS_READY = 1'b0;
    check("t3_release_ready", in_ready, 1);
    check("t3_release_level", level, 1);
    tick();
    en = 1'b0;
    check("t3_refill_level", level, 2);
    check("t3_head", fields[31:0], 200);
    drain();
    check("t3_drained", level, 0);

    // simultaneous push and pop
    send(40, 7);
    send(50, 6);
    en       = 1'b1;
    inD      = 32'd56;
    BS_READY = 1'b1;
    tick();
    en       = 1'b0;
    BS_READY = 1'b0;
    check("t4_level", level, 1);
    check("t4_head", fields[31:0], 50);
    check("t4_tail", fields[6*FIELD_W +: FIELD_W], 56);
    drain();

    // clear mid-packet
    send(60, 7);
    send(70, 4);
    clear = 1'b1;
    en    = 1'b1;
    inD   = 32'd99;
    tick();
    clear = 1'b0;
    en    = 1'b0;
    check("t5_level", level, 0);
    check("t5_valid", hasUnusedData, 0);
    send(80, 7);
    check("t5_new_level", level, 1);
    check("t5_field0", fields[31:0], 80);
    check("t5_field6", fields[6*FIELD_W +: FIELD_W], 86);

    // asynchronous reset mid-packet
    send(90, 3);
    #3 reset = 1'b0;
    #1;
    check("t6_valid", hasUnusedData, 0);
    check("t6_level", level, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_fields", fields, 0);
`ifdef PKTBUF_DROP_CNT_EN
    check("t6_drop", drop_count, 0);
`endif
    #2 reset = 1'b1;
    tick();
    send(110, 7);
    check("t6_new_level", level, 1);
    check("t6_field0", fields[31:0], 110);
    check("t6_field6", fields[6*FIELD_W +: FIELD_W], 116);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
